// File: rtl/arch_defs_pkg.sv
// Shared branch definitions: the eight condition codes and the flag test used
// by the PC unit and by anything that decodes branch instructions.
package arch_defs_pkg;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'd0,
        COND_Z      = 3'd1,
        COND_NZ     = 3'd2,
        COND_C      = 3'd3,
        COND_NC     = 3'd4,
        COND_N      = 3'd5,
        COND_NN     = 3'd6,
        COND_NEVER  = 3'd7
    } cond_t;

    function automatic logic cond_met(cond_t cond, logic z, logic c, logic n);
        logic met;
        met = 1'b0;
        case (cond)
            COND_ALWAYS: met = 1'b1;
            COND_Z:      met = z;
            COND_NZ:     met = ~z;
            COND_C:      met = c;
            COND_NC:     met = ~c;
            COND_N:      met = n;
            COND_NN:     met = ~n;
            default:     met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// Control-unit / flag-register side of the branch PC unit: strobes, flags and
// the PC, stack and perf-counter outputs.
interface branch_pc_unit_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_WIDTH   = 16
);
    import arch_defs_pkg::*;

    localparam int LEVEL_WIDTH = $clog2(STACK_DEPTH + 1);

    logic                   pc_inc_i;
    logic                   br_valid_i;
    cond_t                  br_cond_i;
    logic                   br_call_i;
    logic                   br_ret_i;
    logic [ADDR_WIDTH-1:0]  br_target_i;
    logic                   flag_zero_i;
    logic                   flag_carry_i;
    logic                   flag_negative_i;
    logic [ADDR_WIDTH-1:0]  pc_o;
    logic                   br_taken_o;
    logic [LEVEL_WIDTH-1:0] stack_level_o;
    logic                   stack_err_o;
    logic [CNT_WIDTH-1:0]   taken_cnt_o;
    logic [CNT_WIDTH-1:0]   not_taken_cnt_o;

    modport master (
        output pc_inc_i, br_valid_i, br_cond_i, br_call_i, br_ret_i, br_target_i,
        output flag_zero_i, flag_carry_i, flag_negative_i,
        input  pc_o, br_taken_o, stack_level_o, stack_err_o, taken_cnt_o, not_taken_cnt_o
    );

    modport slave (
        input  pc_inc_i, br_valid_i, br_cond_i, br_call_i, br_ret_i, br_target_i,
        input  flag_zero_i, flag_carry_i, flag_negative_i,
        output pc_o, br_taken_o, stack_level_o, stack_err_o, taken_cnt_o, not_taken_cnt_o
    );

endinterface

// File: rtl/return_stack.sv
// LIFO of return addresses. The top entry is read combinationally so a RET can
// load the PC on the same edge that pops it.
module return_stack #(
    parameter int ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH = 4,
    parameter int LEVEL_WIDTH = $clog2(STACK_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [ADDR_WIDTH-1:0]  push_data,
    output logic [ADDR_WIDTH-1:0]  top_data,
    output logic                   full,
    output logic                   empty,
    output logic [LEVEL_WIDTH-1:0] level
);

    localparam int IDX_WIDTH = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_WIDTH-1:0]  mem [STACK_DEPTH];
    logic [LEVEL_WIDTH-1:0] level_reg;
    logic [LEVEL_WIDTH-1:0] level_next;
    logic [IDX_WIDTH-1:0]   wr_idx;

    assign full   = (level_reg == LEVEL_WIDTH'(STACK_DEPTH));
    assign empty  = (level_reg == '0);
    assign level  = level_reg;
    // Only used while not full, so the level always fits the index width.
    assign wr_idx = IDX_WIDTH'(level_reg);

    always_comb begin
        level_next = level_reg;
        if (push && !full) begin
            level_next = level_reg + LEVEL_WIDTH'(1);
        end else if (pop && !empty) begin
            level_next = level_reg - LEVEL_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_reg <= '0;
        end else begin
            level_reg <= level_next;
        end
    end

    // Contents are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_comb begin
        top_data = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (level_reg == LEVEL_WIDTH'(i + 1)) begin
                top_data = mem[i];
            end
        end
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter with eight-way conditional branches, CALL/RET via a return
// stack and a sticky stack-error flag. Define BRANCH_PERF_CNT_EN to build the
// taken / not-taken performance counters; otherwise those outputs read zero.
module branch_pc_unit
    import arch_defs_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    branch_pc_unit_if.slave bus
);

    localparam int LEVEL_WIDTH = $clog2(STACK_DEPTH + 1);

    logic [ADDR_WIDTH-1:0]  pc_reg;
    logic [ADDR_WIDTH-1:0]  pc_next;
    logic [ADDR_WIDTH-1:0]  stack_top;
    logic [LEVEL_WIDTH-1:0] stack_level;
    logic                   br_taken_reg;
    logic                   stack_err_reg;
    logic                   stack_err_next;
    logic                   stack_full;
    logic                   stack_empty;
    logic                   is_jump;
    logic                   is_call;
    logic                   is_ret;
    logic                   is_illegal;
    logic                   cond_ok;
    logic                   jump_taken;
    logic                   push;
    logic                   pop;
    logic                   taken;

    always_comb begin
        is_illegal = bus.br_valid_i & bus.br_call_i & bus.br_ret_i;
        is_call    = bus.br_valid_i & bus.br_call_i & ~bus.br_ret_i;
        is_ret     = bus.br_valid_i & bus.br_ret_i & ~bus.br_call_i;
        is_jump    = bus.br_valid_i & ~bus.br_call_i & ~bus.br_ret_i;
        cond_ok    = cond_met(bus.br_cond_i, bus.flag_zero_i,
                              bus.flag_carry_i, bus.flag_negative_i);

        jump_taken = is_jump & cond_ok;
        // A taken CALL against a full stack is refused outright: no jump either.
        push       = is_call & cond_ok & ~stack_full;
        pop        = is_ret & ~stack_empty;
        taken      = jump_taken | push | pop;

        stack_err_next = stack_err_reg | is_illegal
                       | (is_ret & stack_empty)
                       | (is_call & cond_ok & stack_full);

        pc_next = pc_reg;
        if (pop) begin
            pc_next = stack_top;
        end else if (push || jump_taken) begin
            pc_next = bus.br_target_i;
        end else if (!bus.br_valid_i && bus.pc_inc_i) begin
            pc_next = pc_reg + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg        <= '0;
            br_taken_reg  <= 1'b0;
            stack_err_reg <= 1'b0;
        end else begin
            pc_reg        <= pc_next;
            br_taken_reg  <= taken;
            stack_err_reg <= stack_err_next;
        end
    end

    return_stack #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_reg),
        .top_data  (stack_top),
        .full      (stack_full),
        .empty     (stack_empty),
        .level     (stack_level)
    );

    assign bus.pc_o          = pc_reg;
    assign bus.br_taken_o    = br_taken_reg;
    assign bus.stack_level_o = stack_level;
    assign bus.stack_err_o   = stack_err_reg;

`ifdef BRANCH_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] taken_cnt_reg;
    logic [CNT_WIDTH-1:0] not_taken_cnt_reg;
    logic                 not_taken;

    // Error cases are neither taken nor not-taken, so they never reach here.
    assign not_taken = (is_jump | is_call) & ~cond_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            taken_cnt_reg     <= '0;
            not_taken_cnt_reg <= '0;
        end else begin
            if (taken && (taken_cnt_reg != '1)) begin
                taken_cnt_reg <= taken_cnt_reg + CNT_WIDTH'(1);
            end
            if (not_taken && (not_taken_cnt_reg != '1)) begin
                not_taken_cnt_reg <= not_taken_cnt_reg + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.taken_cnt_o     = taken_cnt_reg;
    assign bus.not_taken_cnt_o = not_taken_cnt_reg;
`else
    assign bus.taken_cnt_o     = '0;
    assign bus.not_taken_cnt_o = '0;
`endif

endmodule
